dlfloat16_dot_seq: RTL and testbench

Initiator-side sequencer for the registered DLFloat16 multiply-accumulate unit. It accepts a stream of operand pairs, issues one MAC operation per pair, and feeds each registered result back as the addend of the next operation. After `len` pairs it presents the final DLFloat16 dot-product and the OR of all MAC exception flags on a valid/ready result port. It sits between an operand source (buffer or DMA) and the MAC, and it owns the `ena` control of the MAC.

---
 rtl/dlfloat16_dot_seq.sv | 182 ++++++++++++++++++
 tb/tb_dlfloat16_dot_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat16_dot_seq.sv
// dlfloat16_dot_seq: sequencer that drives a registered DLFloat16 MAC to
// compute a dot product over a stream of operand pairs. Each registered MAC
// result is fed back as the addend of the next operation. The final sum and
// the OR of all MAC flags are presented on a valid/ready result port.
//
// Optional feature macro: DLF_DOT_ABORT_EN
//   When defined, an overflow flag reported by the MAC stops further issue.
//   The remaining operand pairs are drained from the stream without being
//   issued, and res_count reports only the pairs that were issued.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. op_ready and res_valid are decoded from registered state
// only, so they never depend combinationally on op_valid or res_ready.
module dlfloat16_dot_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      acc_init,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    output logic [15:0]      mac_d,
    output logic [3:0]       mac_ena,
    input  logic [31:0]      mac_c,
    input  logic [4:0]       mac_flags,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic [4:0]       res_flags,
    output logic [LEN_W-1:0] res_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCEPT  = 3'd1,
        S_EXEC    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    localparam logic [3:0] MAC_OP = 4'b1001;

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [4:0]       flags_q, flags_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic [LEN_W-1:0] cnt_inc;

`ifdef DLF_DOT_ABORT_EN
    // Pairs consumed from the stream so far, including drained ones.
    logic [LEN_W-1:0] dcnt_q, dcnt_d;
    logic [LEN_W-1:0] dcnt_inc;
    assign dcnt_inc = dcnt_q + LEN_W'(1);
`endif

    assign cnt_inc = cnt_q + LEN_W'(1);

    // State and datapath registers; reset returns everything to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef DLF_DOT_ABORT_EN
    // Drain counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dcnt_q <= '0;
        else        dcnt_q <= dcnt_d;
    end
`endif

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        a_d       = a_q;
        b_d       = b_q;
`ifdef DLF_DOT_ABORT_EN
        dcnt_d    = dcnt_q;
`endif
        op_ready  = 1'b0;
        mac_a     = '0;
        mac_b     = '0;
        mac_d     = '0;
        mac_ena   = 4'b0000;
        res_valid = 1'b0;
        res_data  = '0;
        res_flags = '0;
        res_count = '0;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = acc_init;
                    flags_d = '0;
                    cnt_d   = '0;
                    len_d   = len;
                    state_d = (len == '0) ? S_DONE : S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                mac_ena = MAC_OP;
                mac_a   = a_q;
                mac_b   = b_q;
                mac_d   = acc_q;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // The MAC result issued in EXEC is registered and visible now.
                acc_d   = mac_c[15:0];
                flags_d = flags_q | mac_flags;
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == len_q) ? S_DONE : S_ACCEPT;
`ifdef DLF_DOT_ABORT_EN
                if (mac_flags[2] && (cnt_inc < len_q)) begin
                    dcnt_d  = cnt_inc;
                    state_d = S_DRAIN;
                end
`endif
            end
`ifdef DLF_DOT_ABORT_EN
            S_DRAIN: begin
                // Consume the rest of the stream without touching the MAC.
                op_ready = 1'b1;
                if (op_valid) begin
                    dcnt_d = dcnt_inc;
                    if (dcnt_inc == len_q) state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                res_valid = 1'b1;
                res_data  = acc_q;
                res_flags = flags_q;
                res_count = cnt_q;
                if (res_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dlfloat16_dot_seq.sv
// Testbench for dlfloat16_dot_seq. A scripted MAC stub returns values from a
// per-sequence result table; a reference model derives the expected addend
// sequence, result, flags, count and latency from that table.
module tb_dlfloat16_dot_seq;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [15:0]      acc_init = '0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [15:0]      op_a = '0;
    logic [15:0]      op_b = '0;
    logic [15:0]      mac_a, mac_b, mac_d;
    logic [3:0]       mac_ena;
    logic [31:0]      mac_c = '0;
    logic [4:0]       mac_flags = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [15:0]      res_data;
    logic [4:0]       res_flags;
    logic [LEN_W-1:0] res_count;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // clock
    always #5 clk = ~clk;

    dlfloat16_dot_seq #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .acc_init(acc_init),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_d(mac_d), .mac_ena(mac_ena),
        .mac_c(mac_c), .mac_flags(mac_flags),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .res_count(res_count), .busy(busy)
    );

    // Per-sequence tables: operands, scripted MAC results/flags, observations.
    logic [15:0] opa[256];
    logic [15:0] opb[256];
    logic [15:0] r_arr[256];
    logic [4:0]  f_arr[256];
    logic [15:0] obs_a[256];
    logic [15:0] obs_b[256];
    logic [15:0] obs_d[256];
    int stub_cnt = 0;
    int seq_base = 0;

    // MAC stub: registers the scripted result for each enabled operation.
    always @(posedge clk) begin
        int k;
        if (mac_ena == 4'b1001) begin
            k = stub_cnt - seq_base;
            if (k >= 0 && k < 256) begin
                obs_a[k] = mac_a;
                obs_b[k] = mac_b;
                obs_d[k] = mac_d;
                mac_c     <= {16'($urandom), r_arr[k]};
                mac_flags <= f_arr[k];
            end else begin
                mac_c     <= {16'($urandom), 16'h0};
                mac_flags <= 5'd0;
            end
            stub_cnt = stub_cnt + 1;
        end else begin
            mac_c     <= {16'($urandom), 16'h0};
            mac_flags <= 5'd0;
        end
    end

    // Run one sequence from a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_seq(input int n, input logic [15:0] acc, input int stall_first,
                           input int stall_max, input int hold, input bit preset,
                           output int lat_o);
        int i, st, cyc, stalls, k_iss, exp_lat;
        logic [15:0] exp_data, exp_d;
        logic [4:0]  exp_fl;
        if (!preset) begin
            for (int j = 0; j < n; j++) begin
                opa[j]   = 16'($urandom);
                opb[j]   = 16'($urandom);
                r_arr[j] = 16'($urandom);
                f_arr[j] = 5'($urandom) & 5'b11011;
            end
        end
        // reference model
        k_iss = n;
`ifdef DLF_DOT_ABORT_EN
        for (int j = 0; j < n; j++) begin
            if (f_arr[j][2]) begin
                k_iss = j + 1;
                break;
            end
        end
`endif
        exp_data = (k_iss == 0) ? acc : r_arr[k_iss-1];
        exp_fl = 5'd0;
        for (int j = 0; j < k_iss; j++) exp_fl = exp_fl | f_arr[j];

        seq_base = stub_cnt;
        start = 1'b1; len = LEN_W'(n); acc_init = acc;
        @(negedge clk);
        start = 1'b0; len = '0; acc_init = 16'($urandom);
        cyc = 1; i = 0; st = stall_first; stalls = 0;
        while (cyc < 4000) begin
            if (res_valid) break;
            if (mac_ena != 4'b1001) begin
                checks++;
                if (mac_ena !== 4'b0000 || mac_a !== 16'h0 || mac_b !== 16'h0 || mac_d !== 16'h0) begin
                    errors++;
                    $display("FAIL mac_idle: ena=%b a=%h b=%h d=%h, required 0000/0/0/0", mac_ena, mac_a, mac_b, mac_d);
                end
            end
            if (op_ready && i < n) begin
                if (st > 0) begin
                    op_valid = 1'b0;
                    st--;
                    stalls++;
                end else begin
                    op_valid = 1'b1;
                    op_a = opa[i];
                    op_b = opb[i];
                    i++;
                    st = (stall_max > 0) ? $urandom_range(0, stall_max) : 0;
                end
            end else begin
                op_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        op_valid = 1'b0;
        lat_o = cyc;
        checks++;
        if (!res_valid) begin
            errors++;
            $display("FAIL res_timeout: res_valid=%b after %0d cycles, required 1", res_valid, cyc);
        end
        exp_lat = 3 * k_iss + 1 + (n - k_iss) + stalls;
        checks++;
        if (cyc != exp_lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required %0d (n=%0d)", cyc, exp_lat, n);
        end
        checks++;
        if (res_data !== exp_data || res_flags !== exp_fl || res_count !== LEN_W'(k_iss)) begin
            errors++;
            $display("FAIL payload: data=%h flags=%b count=%0d, required %h %b %0d",
                     res_data, res_flags, res_count, exp_data, exp_fl, k_iss);
        end
        checks++;
        if (stub_cnt - seq_base != k_iss) begin
            errors++;
            $display("FAIL issued: %0d MAC ops, required %0d", stub_cnt - seq_base, k_iss);
        end
        for (int j = 0; j < k_iss && j < 256; j++) begin
            exp_d = (j == 0) ? acc : r_arr[j-1];
            checks++;
            if (obs_a[j] !== opa[j] || obs_b[j] !== opb[j] || obs_d[j] !== exp_d) begin
                errors++;
                $display("FAIL mac_operands[%0d]: a=%h b=%h d=%h, required %h %h %h",
                         j, obs_a[j], obs_b[j], obs_d[j], opa[j], opb[j], exp_d);
            end
        end
        // hold result port with res_ready low
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_data || res_flags !== exp_fl ||
                res_count !== LEN_W'(k_iss)) begin
                errors++;
                $display("FAIL hold[%0d]: valid=%b data=%h flags=%b count=%0d, required 1 %h %b %0d",
                         h, res_valid, res_data, res_flags, res_count, exp_data, exp_fl, k_iss);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== 16'h0) begin
            errors++;
            $display("FAIL release: valid=%b busy=%b data=%h, required 0 0 0000", res_valid, busy, res_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; len = 8'd5; acc_init = 16'hABCD;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (op_ready !== 1'b0 || mac_ena !== 4'b0000 || mac_a !== 16'h0 || mac_b !== 16'h0 ||
                mac_d !== 16'h0 || res_valid !== 1'b0 || res_data !== 16'h0 ||
                res_flags !== 5'h0 || res_count !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_values: rdy=%b ena=%b valid=%b data=%h busy=%b, required all 0",
                         op_ready, mac_ena, res_valid, res_data, busy);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_scripted();
        int lat;
        r_arr[0] = 16'h4000; r_arr[1] = 16'h4100; r_arr[2] = 16'h4200;
        for (int j = 0; j < 3; j++) begin
            f_arr[j] = 5'd0;
            opa[j] = 16'($urandom);
            opb[j] = 16'($urandom);
        end
        run_seq(3, 16'h3E00, 0, 0, 0, 1'b1, lat);
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL scripted_latency: got %0d, required 10", lat);
        end
    endtask

    task automatic test_len_zero();
        int lat;
        run_seq(0, 16'h1234, 0, 0, 0, 1'b0, lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL len0_latency: got %0d, required 1", lat);
        end
    endtask

    task automatic test_stall_hold();
        int lat;
        opa[0] = 16'h3E00; opb[0] = 16'h3E00; r_arr[0] = 16'h3E00; f_arr[0] = 5'd0;
        run_seq(1, 16'h0000, 4, 0, 5, 1'b1, lat);
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL stall_latency: got %0d, required 8", lat);
        end
    endtask

    task automatic test_overflow();
        int lat;
        for (int j = 0; j < 4; j++) begin
            opa[j] = 16'($urandom);
            opb[j] = 16'($urandom);
            r_arr[j] = 16'($urandom);
            f_arr[j] = 5'd0;
        end
        r_arr[1] = 16'h7DFE;
        f_arr[1] = 5'b00100;
        run_seq(4, 16'h3C00, 0, 0, 0, 1'b1, lat);
    endtask

    task automatic test_special_values();
        int lat;
        for (int j = 0; j < 3; j++) begin
            opa[j] = 16'hFFFF;
            opb[j] = 16'($urandom);
            f_arr[j] = 5'b10000;
        end
        r_arr[0] = 16'hFFFF; r_arr[1] = 16'hFDFE; r_arr[2] = 16'hFFFF;
        run_seq(3, 16'hFDFE, 1, 1, 1, 1'b1, lat);
    endtask

    task automatic test_random();
        int lat;
        for (int t = 0; t < 20; t++) begin
            run_seq($urandom_range(1, 12), 16'($urandom), $urandom_range(0, 2), 2,
                    $urandom_range(0, 3), 1'b0, lat);
        end
        run_seq(255, 16'($urandom), 0, 0, 0, 1'b0, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int t = 0; t < 4; t++) run_seq(t, 16'($urandom), 0, 0, 0, 1'b0, lat);
    endtask

    task automatic test_reset_mid();
        int seen, cyc, lat;
        for (int j = 0; j < 3; j++) begin
            opa[j] = 16'($urandom);
            opb[j] = 16'($urandom);
            r_arr[j] = 16'($urandom);
            f_arr[j] = 5'd0;
        end
        seq_base = stub_cnt;
        start = 1'b1; len = 8'd3; acc_init = 16'h1111;
        @(negedge clk);
        start = 1'b0;
        seen = 0; cyc = 0;
        while (seen < 2 && cyc < 50) begin
            op_valid = 1'b1; op_a = opa[0]; op_b = opb[0];
            if (mac_ena == 4'b1001) seen++;
            if (seen < 2) begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (seen < 2) begin
            errors++;
            $display("FAIL reset_mid_wait: saw %0d EXEC cycles, required 2", seen);
        end
        rst_n = 1'b0;
        op_valid = 1'b0;
        #1;
        checks++;
        if (mac_ena !== 4'b0000 || mac_d !== 16'h0 || busy !== 1'b0 || op_ready !== 1'b0 ||
            res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ena=%b d=%h busy=%b rdy=%b valid=%b, required all 0",
                     mac_ena, mac_d, busy, op_ready, res_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_seq(1, 16'($urandom), 0, 0, 0, 1'b0, lat);
    endtask

    initial begin
        test_reset();
        test_scripted();
        test_len_zero();
        test_stall_hold();
        test_overflow();
        test_special_values();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
